// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with a registered terminal-count pulse.
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN (periodic reload instead of
// one-shot expiry).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no count in progress (after reset or a load of 0)
// RUN     | counting down, one step per enabled clock
// EXPIRED | one-shot count finished, count holds 0 until the next load
module countdown_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

`ifdef COUNTDOWN_AUTORELOAD_EN
  // The reload value only matters when the count restarts from it.
  logic [WIDTH-1:0] reload_q, reload_d;

  // Reload register: captured alongside count on every load.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) reload_q <= '0;
    else       reload_q <= reload_d;
  end
`endif

  // State, count and terminal-count registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  // Next-state logic: load beats enable; only RUN reacts to enable.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tc_d     = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d  = data;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_d = data;
`endif
      state_d  = (data != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (enable) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
              tc_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              count_d = reload_q;
`else
              count_d = '0;
              state_d = EXPIRED;
`endif
            end else begin
              // A zero count in RUN cannot arise from a load; park safely.
              state_d = IDLE;
            end
          end
        end
        IDLE, EXPIRED: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed and random stimulus against a behavioural
// model of the countdown rules (integer count, running flag, reload value).
module tb_countdown_timer;

  localparam int WIDTH = 5;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst_;
  logic [WIDTH-1:0] data;
  logic             load;
  logic             enable;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             zero;

  int n_cmp;
  int n_err;

  int m_count;
  int m_reload;
  bit m_run;
  bit m_tc;
  int m_enabled;

`ifdef COUNTDOWN_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_   (rst_),
    .data   (data),
    .load   (load),
    .enable (enable),
    .count  (count),
    .tc     (tc),
    .busy   (busy),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count   = 0;
    m_reload  = 0;
    m_run     = 1'b0;
    m_tc      = 1'b0;
    m_enabled = 0;
  endtask

  // Expiry happens when the number of enabled RUN cycles since the load
  // reaches the loaded value.
  task automatic model_edge(input bit l, input int d, input bit e);
    m_tc = 1'b0;
    if (l) begin
      m_count   = d;
      m_reload  = d;
      m_run     = (d != 0);
      m_enabled = 0;
    end else if (m_run && e) begin
      m_enabled++;
      if (m_enabled == m_reload) begin
        m_tc      = 1'b1;
        m_enabled = 0;
        if (AUTO) begin
          m_count = m_reload;
        end else begin
          m_count = 0;
          m_run   = 1'b0;
        end
      end else begin
        m_count = m_reload - m_enabled;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".tc"},    32'(tc),    32'(m_tc));
    check({tag, ".busy"},  32'(busy),  32'(m_run));
    check({tag, ".zero"},  32'(zero),  32'(m_count == 0));
  endtask

  task automatic cyc(input string tag, input bit l, input int d, input bit e);
    load   = l;
    data   = WIDTH'(d);
    enable = e;
    @(posedge clk);
    model_edge(l, d, e);
    #1;
    check_all(tag);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    load   = 1'b0;
    enable = 1'b0;
    data   = '0;
    rst_   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_ = 1'b1;

    // Asynchronous reset mid-count with count=7 in RUN.
    cyc("rst_pre_load", 1'b1, 7, 1'b0);
    cyc("rst_pre_hold", 1'b0, 0, 1'b0);
    #2;
    rst_ = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    cyc("in_reset", 1'b0, 0, 1'b1);
    @(negedge clk);
    rst_ = 1'b1;
    cyc("post_reset_idle", 1'b0, 0, 1'b1);

    // Single shot of 5, then extra enabled cycles.
    cyc("ss_load", 1'b1, 5, 1'b0);
    for (int i = 0; i < 9; i++) cyc("ss_run", 1'b0, 0, 1'b1);
    if (!AUTO) begin
      check("ss_final_count", 32'(count), 32'd0);
      check("ss_final_busy", 32'(busy), 32'd0);
    end

    // Gapped enable.
    cyc("gap_load", 1'b1, 3, 1'b0);
    cyc("gap_e1", 1'b0, 0, 1'b1);
    cyc("gap_e0", 1'b0, 0, 1'b0);
    cyc("gap_e0", 1'b0, 0, 1'b0);
    cyc("gap_e1", 1'b0, 0, 1'b1);
    cyc("gap_e1", 1'b0, 0, 1'b1);
    check("gap_tc", 32'(tc), 32'd1);

    // Load together with enable: no decrement on that edge.
    cyc("prio_load", 1'b1, 9, 1'b1);
    check("prio_count", 32'(count), 32'd9);

    // Restart mid-count, then load 0.
    cyc("rs_load6", 1'b1, 6, 1'b0);
    cyc("rs_en", 1'b0, 0, 1'b1);
    cyc("rs_en", 1'b0, 0, 1'b1);
    check("rs_count4", 32'(count), 32'd4);
    cyc("rs_load2", 1'b1, 2, 1'b0);
    cyc("rs_en", 1'b0, 0, 1'b1);
    cyc("rs_en", 1'b0, 0, 1'b1);
    check("rs_tc", 32'(tc), 32'd1);
    cyc("zero_load", 1'b1, 0, 1'b1);
    cyc("zero_idle", 1'b0, 0, 1'b1);

    // Load coinciding with the terminal edge: load wins, no tc.
    cyc("lt_load", 1'b1, 1, 1'b0);
    cyc("lt_coincide", 1'b1, 4, 1'b1);
    check("lt_no_tc", 32'(tc), 32'd0);

    // Period 3 (autoreload shows reloads; one-shot shows expiry).
    cyc("ar_load", 1'b1, 3, 1'b0);
    for (int i = 0; i < 9; i++) cyc("ar_run", 1'b0, 0, 1'b1);

    // Reload of 1: tc on every enabled cycle in autoreload.
    cyc("ar1_load", 1'b1, 1, 1'b0);
    for (int i = 0; i < 4; i++) cyc("ar1_run", 1'b0, 0, 1'b1);

    // Maximum start value.
    cyc("max_load", 1'b1, MAXV, 1'b0);
    for (int i = 0; i < MAXV + 3; i++) cyc("max_run", 1'b0, 0, 1'b1);

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      bit l;
      int d;
      bit e;
      l = ($urandom_range(0, 11) == 0);
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAXV))
                                      : int'($urandom_range(0, 6));
      e = ($urandom_range(0, 9) < 7);
      cyc("rand", l, d, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
